// File: rtl/seg_scan6_pkg.sv
// ============================================================================
// seg_scan6_pkg : shared display constants, scan FSM states, anode lookup
// Config macro  : SEG_SIGN_EN (adds the seventh, minus-sign slot)
// Revision      : 1.0
// ============================================================================
`default_nettype none

package seg_scan6_pkg;

  localparam logic [7:0] AN_DIGIT0 = 8'b01111111;
  localparam logic [7:0] AN_DIGIT1 = 8'b10111111;
  localparam logic [7:0] AN_DIGIT2 = 8'b11011111;
  localparam logic [7:0] AN_DIGIT3 = 8'b11111011;
  localparam logic [7:0] AN_DIGIT4 = 8'b11111101;
  localparam logic [7:0] AN_DIGIT5 = 8'b11111110;
  localparam logic [7:0] AN_SIGN   = 8'b11110111;
  localparam logic [7:0] AN_BLANK  = 8'hFF;

  localparam logic [6:0] SEG_MINUS = 7'b1000000;

`ifdef SEG_SIGN_EN
  localparam int N_SLOTS = 7;
`else
  localparam int N_SLOTS = 6;
`endif

  localparam int SLOT_W = 3;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [7:0] anode_code(input logic [SLOT_W-1:0] slot);
    logic [7:0] code;
    case (slot)
      3'd0:    code = AN_DIGIT0;
      3'd1:    code = AN_DIGIT1;
      3'd2:    code = AN_DIGIT2;
      3'd3:    code = AN_DIGIT3;
      3'd4:    code = AN_DIGIT4;
      3'd5:    code = AN_DIGIT5;
      3'd6:    code = AN_SIGN;
      default: code = AN_BLANK;
    endcase
    return code;
  endfunction

endpackage : seg_scan6_pkg

`default_nettype wire

// File: rtl/seg_scan6_timebase.sv
// ============================================================================
// scan_timebase : slot divider, slot counter and per-slot BLANK/DRIVE FSM
// Revision      : 1.0
// ============================================================================
`default_nettype none

module scan_timebase
  import seg_scan6_pkg::*;
#(
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              slot_start,
  output logic              in_blank,
  output logic              frame_last
);

  localparam int                CNT_W     = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_SLOTS - 1);

  logic [CNT_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot;
  scan_state_e       state;
  scan_state_e       state_next;
  logic              cnt_last;
  logic              blank_end;

  assign cnt_last = (div_cnt == CNT_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_end = 1'b1;
    end else begin : g_blank
      assign blank_end = (div_cnt == CNT_W'(BLANK_CYCLES - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= '0;
    end else if (cnt_last) begin
      div_cnt <= '0;
      slot    <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (cnt_last) begin
      state_next = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
    end else if (state == BLANK && blank_end) begin
      state_next = DRIVE;
    end
  end

  always_comb begin
    slot_idx   = slot;
    slot_start = (div_cnt == '0);
    in_blank   = (state == BLANK);
    frame_last = cnt_last && (slot == SLOT_LAST);
  end

endmodule : scan_timebase

`default_nettype wire

// File: rtl/seg_scan6.sv
// ============================================================================
// seg_scan6 : six-digit seven-segment scan driver with per-frame snapshot
// Config    : SEG_SIGN_EN adds a minus-sign slot on anode 8'b11110111
// Revision  : 1.0
// ============================================================================
`default_nettype none

module seg_scan6
  import seg_scan6_pkg::*;
#(
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [41:0] data_in,
  input  logic [5:0]  point,
  input  logic        seg_en,
  input  logic        sign,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [7:0]  an_out,
  output logic        frame_done
);

  logic [SLOT_W-1:0] slot_idx;
  logic              slot_start;
  logic              in_blank;
  logic              frame_last;

  scan_timebase #(
    .DIV_CYCLES   (DIV_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_idx   (slot_idx),
    .slot_start (slot_start),
    .in_blank   (in_blank),
    .frame_last (frame_last)
  );

  logic        snap;
  logic [41:0] data_sh;
  logic [5:0]  point_sh;
  logic [41:0] data_cur;
  logic [5:0]  point_cur;
  logic        sign_cur;

  assign snap = slot_start && (slot_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh  <= '0;
      point_sh <= '0;
    end else if (snap) begin
      data_sh  <= data_in;
      point_sh <= point;
    end
  end

  // Bypass on the snapshot cycle so a zero-length blank still shows fresh data
  assign data_cur  = snap ? data_in : data_sh;
  assign point_cur = snap ? point   : point_sh;

`ifdef SEG_SIGN_EN
  logic sign_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_sh <= 1'b0;
    end else if (snap) begin
      sign_sh <= sign;
    end
  end

  assign sign_cur = snap ? sign : sign_sh;
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign sign_cur    = 1'b0;
`endif

  logic [6:0] pat;
  logic       pat_dp;
  logic       visible;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [7:0] an_d;

  always_comb begin
    pat     = '0;
    pat_dp  = 1'b0;
    visible = 1'b1;
    case (slot_idx)
      3'd0: begin pat = data_cur[41:35]; pat_dp = point_cur[5]; end
      3'd1: begin pat = data_cur[34:28]; pat_dp = point_cur[4]; end
      3'd2: begin pat = data_cur[27:21]; pat_dp = point_cur[3]; end
      3'd3: begin pat = data_cur[20:14]; pat_dp = point_cur[2]; end
      3'd4: begin pat = data_cur[13:7];  pat_dp = point_cur[1]; end
      3'd5: begin pat = data_cur[6:0];   pat_dp = point_cur[0]; end
      3'd6: begin pat = SEG_MINUS;       visible = sign_cur;    end
      default: visible = 1'b0;
    endcase
  end

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = AN_BLANK;
    if (seg_en && !in_blank && visible) begin
      seg_d = pat;
      dp_d  = pat_dp;
      an_d  = anode_code(slot_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= '0;
      dp_out     <= 1'b0;
      an_out     <= AN_BLANK;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_d;
      dp_out     <= dp_d;
      an_out     <= an_d;
      frame_done <= frame_last;
    end
  end

endmodule : seg_scan6

`default_nettype wire

// File: tb/tb_seg_scan6.sv
// ============================================================================
// tb_seg_scan6 : directed self-checking bench for seg_scan6 (DIV=8, BLANK=2)
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg_scan6;

  localparam int DIV = 8;
  localparam int BLK = 2;
`ifdef SEG_SIGN_EN
  localparam int NSL = 7;
`else
  localparam int NSL = 6;
`endif
  localparam int FRAME = NSL * DIV;

  localparam logic [41:0] D1 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
  localparam logic [41:0] D2 = {7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [41:0] data_in = '0;
  logic [5:0]  point = '0;
  logic        seg_en = 1'b0;
  logic        sign = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [7:0]  an_out;
  logic        frame_done;

  seg_scan6 #(
    .DIV_CYCLES   (DIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .point      (point),
    .seg_en     (seg_en),
    .sign       (sign),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [41:0] exp_data = '0;
  logic [5:0]  exp_pt   = '0;
  logic        exp_sgn  = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] an_of(input int s);
    case (s)
      0:       return 8'b01111111;
      1:       return 8'b10111111;
      2:       return 8'b11011111;
      3:       return 8'b11111011;
      4:       return 8'b11111101;
      5:       return 8'b11111110;
      default: return 8'b11110111;
    endcase
  endfunction

  // cyc counts clock edges since reset release; cycle p shows the state held before its edge
  task automatic run(input int n, input logic en);
    int p, s, c;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p = cyc % FRAME;
      s = p / DIV;
      c = p % DIV;
      if (p == 0) begin
        exp_data = data_in;
        exp_pt   = point;
        exp_sgn  = sign;
      end
      e_an  = 8'hFF;
      e_seg = '0;
      e_dp  = 1'b0;
      if (en && c >= BLK) begin
        if (s < 6) begin
          e_an  = an_of(s);
          e_seg = exp_data[41-7*s -: 7];
          e_dp  = exp_pt[5-s];
        end else if (exp_sgn) begin
          e_an  = 8'b11110111;
          e_seg = 7'h40;
        end
      end
      check($sformatf("an cyc=%0d", cyc),  64'(an_out),     64'(e_an));
      check($sformatf("seg cyc=%0d", cyc), 64'(seg_out),    64'(e_seg));
      check($sformatf("dp cyc=%0d", cyc),  64'(dp_out),     64'(e_dp));
      check($sformatf("fd cyc=%0d", cyc),  64'(frame_done), 64'(p == FRAME - 1));
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst an",  64'(an_out),     64'hFF);
    check("rst seg", 64'(seg_out),    64'h0);
    check("rst dp",  64'(dp_out),     64'h0);
    check("rst fd",  64'(frame_done), 64'h0);

    // Frame 0: all-zero data; new data arriving in slot 2 must wait a frame
    data_in = '0;
    point   = '0;
    seg_en  = 1'b1;
    sign    = 1'b1;
    rst_n   = 1'b1;
    cyc     = 0;
    run(20, 1'b1);
    data_in = D1;
    point   = 6'b000100;
    run(FRAME - 20, 1'b1);

    // Frame 1: D1 with dp on digit3; change inputs mid-frame
    run(20, 1'b1);
    data_in = D2;
    point   = 6'b100001;
    sign    = 1'b0;
    run(FRAME - 20, 1'b1);

    // Frame 2: D2
    run(FRAME, 1'b1);

    // Frame 3: display disabled, frame_done still pulses
    seg_en = 1'b0;
    run(FRAME, 1'b0);
    seg_en = 1'b1;

    // Frame 4: asynchronous reset in the DRIVE phase of slot 4
    run(4 * DIV + 5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async an",  64'(an_out),     64'hFF);
    check("async seg", 64'(seg_out),    64'h0);
    check("async dp",  64'(dp_out),     64'h0);
    check("async fd",  64'(frame_done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run(FRAME + 2 * DIV, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seg_scan6

`default_nettype wire
